// File: rtl/jam_cost_table.sv
// jam_cost_table
// Cost-matrix responder for the job-assignment machine. Accepts a row-major
// stream of 2^IDX_W x 2^IDX_W cost entries, then answers (W, J) lookups
// combinationally. Table_Ready is what the assignment machine waits on before
// it starts its permutation search.

module jam_cost_table #(
  parameter int DATA_W = 7,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Load_Valid,
  input  logic [DATA_W-1:0] Load_Data,
  output logic              Load_Ready,
  input  logic              Clear,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [DATA_W-1:0] Cost,
  output logic              Table_Ready,
  output logic [CNT_W-1:0]  Access_Count
);

  // The load pointer addresses the whole table as {row, column}.
  localparam int PTR_W = 2 * IDX_W;
  localparam int DEPTH = 1 << PTR_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SERVE
  } state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic                loadReady_q;
  logic                tableReady_q;
  logic [CNT_W-1:0]    accessCount_q;

  // Table storage deliberately carries no reset; contents are only trusted
  // once a full load has completed and Table_Ready is high.
  logic [DATA_W-1:0]   table_q [DEPTH];

  logic                writeEn;
  logic                lastEntry;
  logic [PTR_W-1:0]    readAddr;

  // An entry is accepted only in LOAD, when offered, and when Clear is not
  // discarding progress this cycle (Clear takes priority over the write).
  always_comb begin
    writeEn   = 1'b0;
    lastEntry = 1'b0;
    if (!RST && state_q == LOAD && Load_Valid && !Clear) begin
      writeEn   = 1'b1;
      lastEntry = &ptr_q;
    end
  end

  // Control FSM with registered handshake/status outputs. IDLE is a single
  // settling cycle after reset; the last write moves straight to SERVE so
  // the pointer never has to wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      loadReady_q   <= 1'b0;
      tableReady_q  <= 1'b0;
      accessCount_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q       <= LOAD;
          ptr_q         <= '0;
          loadReady_q   <= 1'b1;
          tableReady_q  <= 1'b0;
          accessCount_q <= '0;
        end
        LOAD: begin
          if (Clear) begin
            ptr_q <= '0;
          end else if (writeEn) begin
            ptr_q <= ptr_q + 1'b1;
            if (lastEntry) begin
              state_q       <= SERVE;
              loadReady_q   <= 1'b0;
              tableReady_q  <= 1'b1;
              accessCount_q <= '0;
            end
          end
        end
        SERVE: begin
          if (Clear) begin
            state_q       <= LOAD;
            ptr_q         <= '0;
            loadReady_q   <= 1'b1;
            tableReady_q  <= 1'b0;
            accessCount_q <= '0;
          end else if (accessCount_q != {CNT_W{1'b1}}) begin
            accessCount_q <= accessCount_q + 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          ptr_q         <= '0;
          loadReady_q   <= 1'b0;
          tableReady_q  <= 1'b0;
          accessCount_q <= '0;
        end
      endcase
    end
  end

  // Row-major table write; the pointer doubles as the {W, J} address.
  always_ff @(posedge CLK) begin
    if (writeEn) begin
      table_q[ptr_q] <= Load_Data;
    end
  end

  // Zero-latency lookup so a registered W/J is answered within the same
  // cycle; the output is forced to zero whenever the table is not valid.
  always_comb begin
    readAddr = {W, J};
    Cost     = '0;
    if (tableReady_q) begin
      Cost = table_q[readAddr];
    end
  end

  assign Load_Ready   = loadReady_q;
  assign Table_Ready  = tableReady_q;
  assign Access_Count = accessCount_q;

endmodule

// File: tb/tb_jam_cost_table.sv
// Self-checking bench for jam_cost_table: a per-cycle expectation is pushed
// by the stimulus side from a behavioural table model and popped by an
// independent monitor on the falling edge.

module tb_jam_cost_table;

  localparam int DATA_W = 7;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 16;
  localparam int NENT   = 64;
  localparam int CNTMAX = 65535;

  logic              CLK;
  logic              RST;
  logic              Load_Valid;
  logic [DATA_W-1:0] Load_Data;
  logic              Load_Ready;
  logic              Clear;
  logic [IDX_W-1:0]  W;
  logic [IDX_W-1:0]  J;
  logic [DATA_W-1:0] Cost;
  logic              Table_Ready;
  logic [CNT_W-1:0]  Access_Count;

  jam_cost_table #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Load_Valid  (Load_Valid),
    .Load_Data   (Load_Data),
    .Load_Ready  (Load_Ready),
    .Clear       (Clear),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .Table_Ready (Table_Ready),
    .Access_Count(Access_Count)
  );

  // 10-unit clock period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit lr;
    bit tr;
    int cost;
    int cnt;
  } exp_t;

  exp_t sbQ[$];

  int testCount = 0;
  int failCount = 0;

  // Behavioural model: how many entries are in, whether the table is being
  // served, and how many serve cycles have elapsed.
  int mTable[NENT];
  int mLoaded  = 0;
  bit mIdle    = 1'b1;
  bit mServing = 1'b0;
  int mServe   = 0;
  bit mKnown   = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Model update for one rising edge, using the inputs as driven.
  task automatic modelEdge();
    if (RST) begin
      mKnown   = 1'b1;
      mIdle    = 1'b1;
      mServing = 1'b0;
      mLoaded  = 0;
      mServe   = 0;
    end else if (mIdle) begin
      mIdle = 1'b0;
    end else if (!mServing) begin
      if (Clear) begin
        mLoaded = 0;
      end else if (Load_Valid) begin
        mTable[mLoaded] = int'(Load_Data);
        mLoaded++;
        if (mLoaded == NENT) begin
          mServing = 1'b1;
          mServe   = 0;
        end
      end
    end else begin
      if (Clear) begin
        mServing = 1'b0;
        mLoaded  = 0;
        mServe   = 0;
      end else if (mServe < CNTMAX) begin
        mServe++;
      end
    end
  endtask

  // Push the expectation for the current cycle, then advance one edge.
  task automatic applyStimulus();
    exp_t e;
    if (mKnown) begin
      e.lr   = !mIdle && !mServing;
      e.tr   = mServing;
      e.cost = mServing ? mTable[int'({W, J})] : 0;
      e.cnt  = mServe;
      sbQ.push_back(e);
    end
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  function automatic int entryValue(input int mode, input int k);
    if (mode == 0) return k;
    if (mode == 1) return 100 - k;
    return int'($urandom_range(0, 127));
  endfunction

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge CLK) begin
    if (sbQ.size() != 0) begin
      exp_t e;
      e = sbQ.pop_front();
      checkOutput("load_ready",   int'(Load_Ready),   int'(e.lr));
      checkOutput("table_ready",  int'(Table_Ready),  int'(e.tr));
      checkOutput("cost",         int'(Cost),         e.cost);
      checkOutput("access_count", int'(Access_Count), e.cnt);
    end
  end

  // Stream a full table; optional load gap, mid-load Clear or mid-load reset.
  task automatic loadTable(input int modeIn, input int gapAt, input int clearAt,
                           input int rstAt, input bit randValid);
    int budget = 0;
    int mode = modeIn;
    bit didGap = 1'b0;
    bit didClear = 1'b0;
    bit didRst = 1'b0;
    while (!mServing && budget < 1000) begin
      RST        = 1'b0;
      Clear      = 1'b0;
      Load_Valid = randValid ? ($urandom_range(0, 3) != 0) : 1'b1;
      Load_Data  = DATA_W'(entryValue(mode, mLoaded));
      W          = IDX_W'($urandom);
      J          = IDX_W'($urandom);
      if (mIdle) Clear = $urandom_range(0, 1) != 0;
      if (!didGap && gapAt >= 0 && !mIdle && mLoaded == gapAt) begin
        didGap = 1'b1;
        for (int g = 0; g < 10; g++) begin
          Load_Valid = 1'b0;
          Load_Data  = DATA_W'($urandom);
          applyStimulus();
          budget++;
        end
      end else if (!didClear && clearAt >= 0 && !mIdle && mLoaded == clearAt) begin
        didClear   = 1'b1;
        Clear      = 1'b1;
        Load_Valid = 1'b1;
        applyStimulus();
        mode = 1;
        budget++;
      end else if (!didRst && rstAt >= 0 && !mIdle && mLoaded == rstAt) begin
        didRst     = 1'b1;
        RST        = 1'b1;
        Load_Valid = 1'b1;
        applyStimulus();
        applyStimulus();
        RST = 1'b0;
        budget += 2;
      end else begin
        applyStimulus();
        budget++;
      end
    end
    Clear      = 1'b0;
    Load_Valid = 1'b0;
    if (!mServing) checkOutput("load_timeout", 1, 0);
  endtask

  // Visit every address once, with Load_Valid noise that must be ignored.
  task automatic sweep();
    for (int i = 0; i < NENT; i++) begin
      {W, J}     = 6'(i);
      Load_Valid = $urandom_range(0, 1) != 0;
      Load_Data  = DATA_W'($urandom);
      applyStimulus();
    end
    Load_Valid = 1'b0;
  endtask

  task automatic randomServe(input int n);
    for (int i = 0; i < n; i++) begin
      W          = IDX_W'($urandom);
      J          = IDX_W'($urandom);
      Load_Valid = $urandom_range(0, 1) != 0;
      Load_Data  = DATA_W'($urandom);
      applyStimulus();
    end
    Load_Valid = 1'b0;
  endtask

  task automatic directedCost(input string name, input int w, input int j, input int expected);
    W = IDX_W'(w);
    J = IDX_W'(j);
    #1;
    checkOutput(name, int'(Cost), expected);
  endtask

  task automatic clearInServe();
    Clear = 1'b1;
    applyStimulus();
    Clear = 1'b0;
    #1;
    checkOutput("clr_table_ready",  int'(Table_Ready),  0);
    checkOutput("clr_cost",         int'(Cost),         0);
    checkOutput("clr_access_count", int'(Access_Count), 0);
    checkOutput("clr_load_ready",   int'(Load_Ready),   1);
  endtask

  initial begin
    RST        = 1'b1;
    Clear      = 1'b0;
    Load_Valid = 1'b0;
    Load_Data  = '0;
    W          = '0;
    J          = '0;
    repeat (3) applyStimulus();
    RST = 1'b0;

    // Value k at index k, continuous valid
    loadTable(0, -1, -1, -1, 1'b0);
    checkOutput("ready_after_load", int'(Table_Ready), 1);
    directedCost("cost_w3j5", 3, 5, 29);
    sweep();
    randomServe(20);
    clearInServe();

    // Ten-cycle valid gap after entry 20
    loadTable(0, 21, -1, -1, 1'b0);
    directedCost("gap_t25", 2, 5, 21);
    directedCost("gap_t77", 7, 7, 63);
    sweep();
    clearInServe();

    // Clear collides with a valid entry at index 40, reload as 100-k
    loadTable(0, -1, 40, -1, 1'b0);
    directedCost("clr_w0j0", 0, 0, 100);
    directedCost("clr_w7j7", 7, 7, 37);
    sweep();
    clearInServe();

    // Random data and valid pattern, reset after 30 entries
    loadTable(2, -1, -1, 30, 1'b1);
    sweep();
    randomServe(30);

    @(negedge CLK);
    #1;
    checkOutput("sb_drain", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
